// File: rtl/key_store.sv
// Round-key store: captures an 11-entry key schedule from the expansion stage
// and serves encrypt/decrypt-ordered reads. Optional zeroization: KEY_STORE_CLEAR_EN.
module key_store (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] rk_in,
    input  logic         rk_in_vld,
    output logic [3:0]   round_sel,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    input  logic         decrypt,
    output logic [127:0] rk_out,
    output logic         rk_out_vld,
    output logic         rd_err
);

    localparam int unsigned KEY_W     = 128;
    localparam int unsigned NUM_SLOTS = 11;
    localparam int unsigned IDX_W     = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [IDX_W-1:0]   wr_cnt;
    logic [IDX_W-1:0]   wr_cnt_d;
    logic [IDX_W-1:0]   round_sel_d;
    logic               busy_d;
    logic               keys_ready_d;
    logic               slot_we_c;
    logic               rd_ok_c;
    logic               rd_bad_c;
    logic               rd_in_range_c;
    logic [IDX_W-1:0]   rd_slot_c;
    logic [KEY_W-1:0]   slots [NUM_SLOTS];

    // State and write-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_cnt <= '0;
        end else begin
            state  <= state_d;
            wr_cnt <= wr_cnt_d;
        end
    end

    // Next-state, slot write enable and read qualification
    always_comb begin
        state_d       = state;
        wr_cnt_d      = wr_cnt;
        slot_we_c     = 1'b0;
        rd_in_range_c = (rd_round <= LAST_IDX);
        rd_slot_c     = decrypt ? IDX_W'(LAST_IDX - rd_round) : rd_round;

        unique case (state)
            IDLE:  ;
            CAPTURE: begin
                if (rk_in_vld) begin
                    slot_we_c = 1'b1;
                    if (wr_cnt == LAST_IDX) begin
                        state_d  = READY;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt + IDX_W'(1);
                    end
                end
            end
            READY: ;
            default: state_d = IDLE;
        endcase

        // A new start abandons whatever was in progress and drops any read
        if (start) begin
            state_d   = CAPTURE;
            wr_cnt_d  = '0;
            slot_we_c = 1'b0;
        end

        busy_d       = (state_d == CAPTURE);
        keys_ready_d = (state_d == READY);
        round_sel_d  = (state_d == CAPTURE) ? wr_cnt_d : '0;

        rd_ok_c  = rd_en && !start && (state == READY) && rd_in_range_c;
        rd_bad_c = rd_en && !start && !((state == READY) && rd_in_range_c);
    end

`ifdef KEY_STORE_CLEAR_EN
    // Zeroizing key storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '{default: '0};
        end else if (start) begin
            slots <= '{default: '0};
        end else if (slot_we_c) begin
            slots[wr_cnt] <= rk_in;
        end
    end
`else
    // Plain key storage; contents survive reset and start
    always_ff @(posedge clk) begin
        if (slot_we_c) begin
            slots[wr_cnt] <= rk_in;
        end
    end
`endif

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_sel  <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            rk_out     <= '0;
            rk_out_vld <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            round_sel  <= round_sel_d;
            busy       <= busy_d;
            keys_ready <= keys_ready_d;
            rk_out_vld <= rd_ok_c;
            rd_err     <= rd_bad_c;
            if (rd_ok_c) begin
                rk_out <= slots[rd_slot_c];
            end
`ifdef KEY_STORE_CLEAR_EN
            else if (start) begin
                rk_out <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_store.sv
// Scoreboard bench for key_store: driver updates a behavioural model and queues
// expected read responses; a monitor pops and compares whenever a response appears.
module tb_key_store;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] rk_in = '0;
    logic         rk_in_vld = 1'b0;
    logic [3:0]   round_sel;
    logic         busy;
    logic         keys_ready;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = '0;
    logic         decrypt = 1'b0;
    logic [127:0] rk_out;
    logic         rk_out_vld;
    logic         rd_err;

    key_store dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rk_in      (rk_in),
        .rk_in_vld  (rk_in_vld),
        .round_sel  (round_sel),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .decrypt    (decrypt),
        .rk_out     (rk_out),
        .rk_out_vld (rk_out_vld),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           err;
        logic [127:0] data;
    } resp_t;

    resp_t        exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    // Behavioural model of the store
    bit           m_cap;
    bit           m_ready;
    int           m_cnt;
    logic [127:0] m_keys [11];
    logic [127:0] m_rk;

    logic [127:0] fips [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_cap   = 0;
        m_ready = 0;
        m_cnt   = 0;
        m_rk    = '0;
`ifdef KEY_STORE_CLEAR_EN
        for (int i = 0; i < 11; i++) m_keys[i] = '0;
`endif
    endtask

    // One clock of stimulus: model update before the edge, status check after it
    task automatic step(input bit s, input bit v, input logic [127:0] k,
                        input bit re, input logic [3:0] rr, input bit dc);
        int slot;
        @(negedge clk);
        start     = s;
        rk_in_vld = v;
        rk_in     = k;
        rd_en     = re;
        rd_round  = rr;
        decrypt   = dc;
        if (s) begin
            m_cap   = 1;
            m_ready = 0;
            m_cnt   = 0;
`ifdef KEY_STORE_CLEAR_EN
            for (int i = 0; i < 11; i++) m_keys[i] = '0;
            m_rk = '0;
`endif
        end else begin
            if (re) begin
                if (m_ready && rr <= 4'd10) begin
                    slot = dc ? 10 - int'(rr) : int'(rr);
                    m_rk = m_keys[slot];
                    exp_q.push_back('{err: 1'b0, data: m_rk});
                end else begin
                    exp_q.push_back('{err: 1'b1, data: m_rk});
                end
            end
            if (m_cap && v) begin
                m_keys[m_cnt] = k;
                if (m_cnt == 10) begin
                    m_cap   = 0;
                    m_ready = 1;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("round_sel", 128'(round_sel), m_cap ? 128'(m_cnt) : 128'(0));
        chk("busy", 128'(busy), 128'(m_cap));
        chk("keys_ready", 128'(keys_ready), 128'(m_ready));
        chk("rk_out_hold", rk_out, m_rk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0; rk_in_vld = 0; rk_in = '0; rd_en = 0; rd_round = '0; decrypt = 0;
        rst_n = 1'b0;
        #1;
        model_clear();
        exp_q.delete();
        chk("rst_round_sel", 128'(round_sel), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_keys_ready", 128'(keys_ready), 128'(0));
        chk("rst_rk_out", rk_out, 128'(0));
        chk("rst_rk_out_vld", 128'(rk_out_vld), 128'(0));
        chk("rst_rd_err", 128'(rd_err), 128'(0));
`ifdef KEY_STORE_CLEAR_EN
        chk("rst_slot0_peek", dut.slots[0], 128'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor
    always @(posedge clk) begin
        resp_t e;
        #1;
        if (rst_n) begin
            if (rk_out_vld || rd_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_resp: got vld=%b err=%b expected no response", rk_out_vld, rd_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", 128'(rd_err), 128'(e.err));
                    chk("resp_vld", 128'(rk_out_vld), 128'(!e.err));
                    chk("resp_rk_out", rk_out, e.data);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_resp: got no response expected err=%b data=%h", e.err, e.data);
            end
        end
    end

    initial begin
        logic [127:0] k;
        do_reset();

        // FIPS-197 schedule capture
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, fips[i], 0, 0, 0);
        chk("fips_ready", 128'(keys_ready), 128'(1));

        // Encrypt and decrypt ordered reads against the published schedule
        step(0, 0, '0, 1, 4'd1, 0);
        chk("fips_rd1_enc", rk_out, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        step(0, 0, '0, 1, 4'd0, 1);
        chk("fips_rd0_dec", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        step(0, 0, '0, 1, 4'd11, 0);
        step(0, 1, rnd_key(), 1, 4'd15, 1);
        for (int i = 0; i < 22; i++) step(0, 0, '0, 1, 4'(i % 11), 1'(i / 11));
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom_range(0, 1)), rnd_key(), 1, 4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

        // Start collides with a read
        step(1, 0, '0, 1, 4'd3, 0);
        chk("start_wins_busy", 128'(busy), 128'(1));

        // Stalled capture at slot 5 with reads rejected while busy
        for (int i = 0; i < 5; i++) step(0, 1, rnd_key(), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, rnd_key(), 1, 4'(i), 0);
        chk("stall_round_sel", 128'(round_sel), 128'(5));
        for (int i = 5; i < 11; i++) step(0, 1, rnd_key(), 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, '0, 1, 4'(i), 0);

        // Restart at slot 7, then reset during the new capture
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, rnd_key(), 0, 0, 0);
        step(1, 1, rnd_key(), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, rnd_key(), 0, 0, 0);
        do_reset();
        step(0, 0, '0, 1, 4'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            k = rnd_key();
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), k,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end

        step(0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_store.md
KEY_STORE -- requirements
Module: key_store

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; begins capture of a new 11-key schedule.
REQ-004 rk_in  input  128  round key from the key-expansion stage.
REQ-005 rk_in_vld  input  1  rk_in holds the key for slot round_sel this cycle.
REQ-006 round_sel  output  4  slot index currently being captured; drives the expansion stage's round select.
REQ-007 busy  output  1  high while in CAPTURE.
REQ-008 keys_ready  output  1  high while in READY; all 11 slots valid.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_round  input  4  cipher round number, 0..10.
REQ-011 decrypt  input  1  1: slot = 10 - rd_round; 0: slot = rd_round.
REQ-012 rk_out  output  128  registered round key.
REQ-013 rk_out_vld  output  1  one-cycle pulse; rk_out updated this cycle.
REQ-014 rd_err  output  1  one-cycle pulse; read rejected.

Function
REQ-015 Storage SHALL be 11 x 128-bit registers, slots 0..10.
REQ-016 The FSM SHALL have states IDLE, CAPTURE and READY.
REQ-017 start in any state SHALL enter CAPTURE next cycle with wr_cnt=0 and keys_ready=0; any in-progress capture is abandoned.
REQ-018 In CAPTURE, each cycle with rk_in_vld=1 SHALL write rk_in to slot wr_cnt and increment wr_cnt.
REQ-019 rk_in_vld=0 in CAPTURE SHALL stall with no write and no increment.
REQ-020 Writing slot 10 SHALL enter READY on the next cycle, with keys_ready=1 and busy=0.
REQ-021 rk_in_vld outside CAPTURE SHALL be ignored.
REQ-022 round_sel SHALL equal wr_cnt in CAPTURE and 0 otherwise.
REQ-023 Valid read: rd_en=1, state READY, rd_round<=10, no start in the same cycle.
  - rk_out SHALL load the mapped slot.
  - rk_out_vld SHALL pulse on the next cycle (1-cycle latency).
REQ-024 Rejected read: rd_en=1 with state not READY or rd_round>10.
  - rd_err SHALL pulse on the next cycle.
  - rk_out SHALL hold its value.
  - rk_out_vld SHALL stay 0.
REQ-025 start and rd_en in the same cycle: start SHALL win; the read is dropped with no rd_err and no rk_out_vld.
REQ-026 Back-to-back reads on consecutive cycles SHALL each be served at full throughput.
REQ-027 READY SHALL persist until the next start or reset.

Reset
REQ-028 On rst_n low, asynchronously:
  - state=IDLE and wr_cnt=0.
  - round_sel=0, busy=0, keys_ready=0.
  - rk_out=0, rk_out_vld=0, rd_err=0.
REQ-029 Reset during CAPTURE SHALL discard partial keys; a new start is required.

Configuration
REQ-030 Macro KEY_STORE_CLEAR_EN SHALL control slot zeroization.
  - Defined: all 11 slots clear to zero on reset and in the cycle start is accepted, and rk_out clears to zero on start.
  - Not defined: slots have no reset and are not cleared on start; old contents remain until overwritten.
  - Interface and timing are identical in both builds.

Verification
REQ-031 Start, then feed the FIPS-197 C.1 schedule (key 000102..0f) on 11 consecutive rk_in_vld cycles -> round_sel steps 0..10, keys_ready=1 on cycle 12.
REQ-032 In READY, rd_round=1, decrypt=0 -> next cycle rk_out=d6aa74fdd2af72fadaa678f1d6ab76fe, rk_out_vld=1; rd_round=0, decrypt=1 -> rk_out=13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 rd_en while busy, or rd_round=11 in READY -> rd_err pulse, rk_out unchanged, rk_out_vld=0.
REQ-034 rk_in_vld deasserted for 3 cycles mid-capture at round_sel=5 -> round_sel holds at 5, no slot written, capture completes correctly afterwards.
REQ-035 start asserted at round_sel=7, then rst_n pulsed during the new capture -> all outputs at reset values, keys_ready=0; with KEY_STORE_CLEAR_EN defined, a debug peek of slot 0 reads zero.
REQ-036 start and rd_en in the same cycle in READY -> busy=1 next cycle, no rk_out_vld and no rd_err.
